timer0_count_unit: RTL

- Counting and flag engine for Timer/Counter0 of the ATMega32A emulator.
- Consumes the stored TCCR0, OCR0 and TIMSK register values.
- Produces the next TCNT0 value, the TOV0/OCF0 interrupt flags, the interrupt requests and the OC0 pin.
- Contains the clock-select prescaler and the T0 external pin synchroniser. It replaces a free-running count clock with a single-clock tick enable.

---
 rtl/timer0_count_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/timer0_count_unit.sv
// Timer/Counter0 counting and flag engine for the ATMega32A emulator.
// A single system clock drives everything. The prescaler taps and the
// synchronised T0 pin edges are turned into a registered one-cycle tick
// enable. The tick advances TCNT0, raises TOV0/OCF0 and drives OC0.
module timer0_count_unit #(
   parameter int PRESCALER_WIDTH = 10,  // >= 10 so the /1024 tap exists
   parameter int SYNC_STAGES     = 2    // >= 2 synchroniser flops on T0
) (
   input  logic       sysClock,
   input  logic       system_reset,
   input  logic [7:0] TCCR_in,
   input  logic [7:0] OCR_in,
   input  logic [7:0] TIMSK_in,
   input  logic [7:0] TCNT_write_data,
   input  logic       TCNT_write_enable,
   input  logic [7:0] TIFR_write_data,
   input  logic       TIFR_write_enable,
   input  logic       ovf_ack,
   input  logic       comp_ack,
   input  logic       prescaler_reset,
   input  logic       T0_pin,
   output logic [7:0] TCNT_out,
   output logic [7:0] TIFR_out,
   output logic       timer_tick,
   output logic       ovf_irq,
   output logic       comp_irq,
   output logic       OC0_out
);

   localparam logic [2:0] CS_STOP  = 3'd0;
   localparam logic [2:0] CS_DIV1  = 3'd1;
   localparam logic [2:0] CS_DIV8  = 3'd2;
   localparam logic [2:0] CS_DIV64 = 3'd3;
   localparam logic [2:0] CS_DIV256  = 3'd4;
   localparam logic [2:0] CS_DIV1024 = 3'd5;
   localparam logic [2:0] CS_T0_FALL = 3'd6;
   localparam logic [2:0] CS_T0_RISE = 3'd7;

   logic [PRESCALER_WIDTH-1:0] presc;
   logic [PRESCALER_WIDTH-1:0] presc_next;
   logic [SYNC_STAGES-1:0]     t0_sync;
   logic                       t0_prev;
   logic                       t0_rise;
   logic                       t0_fall;
   logic                       tick_sel_p0;
   logic                       tick_p1;
   logic [7:0]                 tcnt;
   logic                       cmp_block;
   logic                       tov;
   logic                       ocf;
   logic                       oc0;

   logic [2:0] cs;
   logic [1:0] com;
   logic       ctc_mode;
   logic       at_top;
   logic       at_ocr;
   logic       tick_used;
   logic       match;
   logic       ovf_set;
   logic       tov_clr;
   logic       ocf_clr;
   logic       unused_bits;

   // Register field decode; WGM00=1 is unsupported and falls back to normal.
   assign cs       = TCCR_in[2:0];
   assign com      = TCCR_in[5:4];
   assign ctc_mode = TCCR_in[3] & ~TCCR_in[6];

   assign unused_bits = ^{TCCR_in[7], TIMSK_in[7:2], TIFR_write_data[7:2]};

   // Next prescaler value; PSR10 forces zero for this cycle.
   always_comb begin
      presc_next = presc + 1'b1;
      if (prescaler_reset) begin
         presc_next = '0;
      end
   end

   // Free-running prescaler.
   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         presc <= '0;
      end else begin
         presc <= presc_next;
      end
   end

   // T0 pin synchroniser plus one delayed copy for edge detection.
   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         t0_sync <= '0;
         t0_prev <= 1'b0;
      end else begin
         t0_sync <= {t0_sync[SYNC_STAGES-2:0], T0_pin};
         t0_prev <= t0_sync[SYNC_STAGES-1];
      end
   end

   assign t0_rise =  t0_sync[SYNC_STAGES-1] & ~t0_prev;
   assign t0_fall = ~t0_sync[SYNC_STAGES-1] &  t0_prev;

   // Clock-select mux. Prescaler taps look at presc_next so the registered
   // tick lines up with the cycle in which the prescaler shows all ones.
   always_comb begin
      tick_sel_p0 = 1'b0;
      case (cs)
         CS_STOP:    tick_sel_p0 = 1'b0;
         CS_DIV1:    tick_sel_p0 = 1'b1;
         CS_DIV8:    tick_sel_p0 = &presc_next[2:0];
         CS_DIV64:   tick_sel_p0 = &presc_next[5:0];
         CS_DIV256:  tick_sel_p0 = &presc_next[7:0];
         CS_DIV1024: tick_sel_p0 = &presc_next[9:0];
         CS_T0_FALL: tick_sel_p0 = t0_fall;
         CS_T0_RISE: tick_sel_p0 = t0_rise;
         default:    tick_sel_p0 = 1'b0;
      endcase
   end

   // ---- stage p0 -> p1: registered tick enable ----
   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         tick_p1 <= 1'b0;
      end else begin
         tick_p1 <= tick_sel_p0;
      end
   end

   // A CPU write swallows the tick, so it neither counts nor matches.
   assign at_top    = (tcnt == 8'hFF);
   assign at_ocr    = (tcnt == OCR_in);
   assign tick_used = tick_p1 & ~TCNT_write_enable;
   assign match     = tick_used & at_ocr & ~cmp_block;
   assign ovf_set   = tick_used & at_top;
   assign tov_clr   = (TIFR_write_enable & TIFR_write_data[0]) | ovf_ack;
   assign ocf_clr   = (TIFR_write_enable & TIFR_write_data[1]) | comp_ack;

   // Counter and compare-block bit; CPU write outranks the tick.
   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         tcnt      <= 8'h00;
         cmp_block <= 1'b0;
      end else if (TCNT_write_enable) begin
         tcnt      <= TCNT_write_data;
         cmp_block <= 1'b1;
      end else if (tick_p1) begin
         cmp_block <= 1'b0;
         if ((ctc_mode && at_ocr) || at_top) begin
            tcnt <= 8'h00;
         end else begin
            tcnt <= tcnt + 8'd1;
         end
      end
   end

   // Interrupt flags; a hardware set wins over a clear in the same cycle.
   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         tov <= 1'b0;
         ocf <= 1'b0;
      end else begin
         tov <= ovf_set | (tov & ~tov_clr);
         ocf <= match   | (ocf & ~ocf_clr);
      end
   end

   // OC0 pin action on compare match; COM0=0 keeps the pin low.
   always_ff @(posedge sysClock) begin
      if (!system_reset) begin
         oc0 <= 1'b0;
      end else if (com == 2'd0) begin
         oc0 <= 1'b0;
      end else if (match) begin
         case (com)
            2'd1:    oc0 <= ~oc0;
            2'd2:    oc0 <= 1'b0;
            2'd3:    oc0 <= 1'b1;
            default: oc0 <= 1'b0;
         endcase
      end
   end

   assign TCNT_out   = tcnt;
   assign TIFR_out   = {6'b000000, ocf, tov};
   assign timer_tick = tick_p1;
   assign ovf_irq    = tov & TIMSK_in[0];
   assign comp_irq   = ocf & TIMSK_in[1];
   assign OC0_out    = oc0;

endmodule
